// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: shared MEM-stage state encoding and constants
package riscv_pipe_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} mem_state_t;
  localparam logic [1:0] RESULTSRC_MEM = 2'b01;
  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/dmem_timeout_cnt.sv
// dmem_timeout_cnt: clearable up-counter flagging the last permitted wait cycle
module dmem_timeout_cnt #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (!rst || clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign tc = (TIMEOUT > 0) && (cnt == W'(TIMEOUT - 1));
endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences MEM-stage loads/stores over a req/ack data memory
module dmem_access_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int          TIMEOUT   = 64,
  parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWrite_M,
  input  logic [1:0]  ResultSrc_M,
  input  logic [31:0] ALUResult_M,
  input  logic [31:0] WriteData_M,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] ReadData_M,
  output logic        Stall_M,
  output logic        Flush_W,
  output logic        mem_err
);
  mem_state_t state;
  logic access;
  logic misaligned;
  logic tc;
  assign access = MemWrite_M | (ResultSrc_M == RESULTSRC_MEM);
  assign misaligned = |ALUResult_M[1:0];
  assign Stall_M = (state == IDLE && access) || state == BUSY;
  assign Flush_W = Stall_M;
  dmem_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(state != BUSY),
    .en(state == BUSY),
    .tc(tc)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      ReadData_M <= '0;
      mem_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (access) begin
          if (misaligned) begin
            mem_err    <= 1'b1;
            ReadData_M <= ERR_RDATA;
            state      <= DONE;
          end else begin
            mem_req   <= 1'b1;
            mem_we    <= MemWrite_M;
            mem_addr  <= {ALUResult_M[31:2], 2'b00};
            mem_wdata <= WriteData_M;
            state     <= BUSY;
          end
        end
        BUSY: if (mem_ack) begin
          mem_req <= 1'b0;
          if (!mem_we) ReadData_M <= mem_rdata;
          state <= DONE;
        end else if (tc) begin
          mem_req    <= 1'b0;
          mem_err    <= 1'b1;
          ReadData_M <= ERR_RDATA;
          state      <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: randomized scoreboard bench for dmem_access_ctrl
module tb_dmem_access_ctrl;
  localparam int TO = 4;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MemWrite_M = 1'b0;
  logic [1:0]  ResultSrc_M = 2'b00;
  logic [31:0] ALUResult_M = '0;
  logic [31:0] WriteData_M = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_req, mem_we, Stall_M, Flush_W, mem_err;
  logic [31:0] mem_addr, mem_wdata, ReadData_M;
  dmem_access_ctrl #(.TIMEOUT(TO), .ERR_RDATA(ERR)) dut (
    .clk(clk), .rst(rst), .MemWrite_M(MemWrite_M), .ResultSrc_M(ResultSrc_M),
    .ALUResult_M(ALUResult_M), .WriteData_M(WriteData_M), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .ReadData_M(ReadData_M), .Stall_M(Stall_M),
    .Flush_W(Flush_W), .mem_err(mem_err)
  );
  always #5 clk = ~clk;
  typedef struct {int stall; int reqc; logic [31:0] rd; logic err;} cpl_t;
  typedef struct {logic we; logic [31:0] addr; logic [31:0] wd;} txn_t;
  cpl_t cpl_q[$];
  txn_t txn_q[$];
  int dly_q[$];
  logic [31:0] m_mem[logic [31:0]];
  logic [31:0] r_mem[logic [31:0]];
  logic [31:0] rd_m = '0;
  logic err_m = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;
  function automatic logic [31:0] seed_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  bit r_busy = 1'b0;
  int r_cnt = 0;
  int r_d = 0;
  always @(negedge clk) begin
    if (mem_req) begin
      if (!r_busy) begin
        r_busy = 1'b1;
        r_cnt = 0;
        r_d = dly_q.size() != 0 ? dly_q.pop_front() : 1000;
      end
      r_cnt++;
      mem_ack = (r_cnt == r_d);
      if (mem_ack && mem_we) r_mem[mem_addr] = mem_wdata;
      mem_rdata = (mem_ack && !mem_we) ? (r_mem.exists(mem_addr) ? r_mem[mem_addr] : seed_word(mem_addr)) : $urandom;
    end else begin
      r_busy = 1'b0;
      mem_ack = ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom;
    end
  end
  int run = 0;
  int reqc = 0;
  bit prev_req = 1'b0;
  txn_t t;
  cpl_t c;
  always @(negedge clk) if (mon_en) begin
    if (mem_req && !prev_req) begin
      if (txn_q.size() == 0) chk("unexpected_req", 32'(mem_req), 32'(0));
      else begin
        t = txn_q.pop_front();
        chk("req_we", 32'(mem_we), 32'(t.we));
        chk("req_addr", mem_addr, t.addr);
        chk("req_wdata", mem_wdata, t.wd);
      end
    end
    prev_req = mem_req;
    if (Stall_M) begin
      run++;
      reqc += int'(mem_req);
    end else if (run > 0) begin
      if (cpl_q.size() == 0) chk("unexpected_done", 32'(run), 32'(0));
      else begin
        c = cpl_q.pop_front();
        chk("stall_cycles", 32'(run), 32'(c.stall));
        chk("req_cycles", 32'(reqc), 32'(c.reqc));
        chk("done_rdata", ReadData_M, c.rd);
        chk("done_err", 32'(mem_err), 32'(c.err));
        chk("done_req", 32'(mem_req), 32'(0));
        chk("done_flush", 32'(Flush_W), 32'(0));
      end
      run = 0;
      reqc = 0;
    end
  end
  task automatic drive_idle();
    int r = $urandom_range(0, 2);
    MemWrite_M = 1'b0;
    ResultSrc_M = r == 0 ? 2'b00 : 2'(r + 1);
    ALUResult_M = $urandom;
    WriteData_M = $urandom;
  endtask
  task automatic issue();
    int k = $urandom_range(0, 99);
    logic we = k < 50;
    logic mis = k >= 85;
    logic [31:0] a = 32'h100 + 32'(4 * $urandom_range(0, 15));
    logic [31:0] wd = $urandom;
    int d = $urandom_range(1, 6);
    int busy = d < TO ? d : TO;
    if (k < 15) begin
      drive_idle();
      return;
    end
    if (mis) a = a + 32'($urandom_range(1, 3));
    MemWrite_M = we;
    ResultSrc_M = we ? 2'($urandom) : 2'b01;
    ALUResult_M = a;
    WriteData_M = wd;
    if (mis) begin
      err_m = 1'b1;
      rd_m = ERR;
      cpl_q.push_back(cpl_t'{1, 0, rd_m, err_m});
    end else begin
      dly_q.push_back(d);
      txn_q.push_back(txn_t'{we, a, wd});
      if (d > TO) begin
        err_m = 1'b1;
        rd_m = ERR;
      end else if (we) m_mem[a] = wd;
      else rd_m = m_mem.exists(a) ? m_mem[a] : seed_word(a);
      cpl_q.push_back(cpl_t'{1 + busy, busy, rd_m, err_m});
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(mem_req), 32'(0));
    chk("rst_we", 32'(mem_we), 32'(0));
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_rdata", ReadData_M, 32'h0);
    chk("rst_err", 32'(mem_err), 32'(0));
    chk("rst_stall_idle", 32'(Stall_M), 32'(0));
    ResultSrc_M = 2'b01;
    #1 chk("rst_stall_access", 32'(Stall_M), 32'(1));
    ResultSrc_M = 2'b00;
    @(posedge clk);
    #1 rst = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      int cyc;
      issue();
      for (cyc = 0; cyc < 20; cyc++) begin
        @(negedge clk);
        if (!Stall_M) break;
      end
      if (cyc == 20) begin
        n_cmp++;
        n_bad++;
        $display("FAIL stall_bound: stall still high after %0d cycles, required low", cyc);
        break;
      end
      @(posedge clk);
      #1;
    end
    drive_idle();
    repeat (4) @(negedge clk);
    chk("cpl_drained", 32'(cpl_q.size()), 32'(0));
    chk("txn_drained", 32'(txn_q.size()), 32'(0));
    chk("dly_drained", 32'(dly_q.size()), 32'(0));
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    MemWrite_M = 1'b0;
    ResultSrc_M = 2'b01;
    ALUResult_M = 32'h103;
    @(negedge clk);
    chk("mis_stall", 32'(Stall_M), 32'(1));
    chk("mis_noreq", 32'(mem_req), 32'(0));
    @(posedge clk);
    #1 ResultSrc_M = 2'b00;
    @(negedge clk);
    chk("mis_err", 32'(mem_err), 32'(1));
    chk("mis_rdata", ReadData_M, ERR);
    chk("mis_done_stall", 32'(Stall_M), 32'(0));
    chk("mis_done_req", 32'(mem_req), 32'(0));
    @(posedge clk);
    #1;
    ResultSrc_M = 2'b01;
    ALUResult_M = 32'h100;
    dly_q.push_back(100);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("busy2_req", 32'(mem_req), 32'(1));
    chk("busy2_addr", mem_addr, 32'h100);
    rst = 1'b0;
    @(negedge clk);
    chk("busy_rst_req", 32'(mem_req), 32'(0));
    chk("busy_rst_err", 32'(mem_err), 32'(0));
    chk("busy_rst_rdata", ReadData_M, 32'h0);
    chk("busy_rst_stall", 32'(Stall_M), 32'(1));
    ResultSrc_M = 2'b00;
    #1 chk("busy_rst_stall_idle", 32'(Stall_M), 32'(0));
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences the MEM stage of the 5-stage RISC-V pipeline against a variable-latency data memory that uses a req/ack handshake.
- Detects a load or store held in the EX/MEM register and issues one memory transaction for it.
- Stalls the F/D/E/M pipeline registers and bubbles the MEM/WB register until that transaction completes.
- Flags misaligned accesses and memory timeouts through a sticky error output.

Parameters:
- TIMEOUT, 64: maximum BUSY cycles spent waiting for mem_ack; 0 disables the timeout.
- ERR_RDATA, 32'h0000_0000: read data returned on a timed-out or misaligned load.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- MemWrite_M  in  1  store in MEM stage.
- ResultSrc_M  in  2  value 2'b01 marks a load in MEM stage.
- ALUResult_M  in  32  byte address.
- WriteData_M  in  32  store data.
- mem_ack  in  1  memory completion; valid only while mem_req=1.
- mem_rdata  in  32  load data, valid with mem_ack.
- mem_req  out  1  registered transaction request.
- mem_we  out  1  registered write enable.
- mem_addr  out  32  registered word address; bits [1:0] are always 0.
- mem_wdata  out  32  registered store data.
- ReadData_M  out  32  captured load data, valid in DONE.
- Stall_M  out  1  hold the PC and the IF/ID, ID/EX and EX/MEM registers.
- Flush_W  out  1  load a bubble into MEM/WB; equals Stall_M.
- mem_err  out  1  sticky error flag; cleared only by reset.

Behaviour:
- access = MemWrite_M | (ResultSrc_M == 2'b01). A write takes priority if both are set.
- misaligned = (ALUResult_M[1:0] != 0). Word accesses only.
- The FSM has three states: IDLE, BUSY and DONE.
- IDLE, access=0: stay in IDLE.
- IDLE, access=1, misaligned=1:
  - Set mem_err.
  - Set ReadData_M = ERR_RDATA.
  - Go to DONE; no request is issued.
- IDLE, access=1, misaligned=0:
  - At the next edge: mem_req<=1, mem_we<=MemWrite_M, mem_addr<=ALUResult_M, mem_wdata<=WriteData_M.
  - Clear the timeout counter and go to BUSY.
- BUSY:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable.
  - The counter increments every cycle.
- BUSY, mem_ack=1:
  - mem_req<=0.
  - ReadData_M <= mem_rdata for a load; ReadData_M is unchanged for a store.
  - Go to DONE.
- BUSY, mem_ack=0 and counter==TIMEOUT-1 (TIMEOUT>0):
  - mem_req<=0 and mem_err<=1.
  - ReadData_M <= ERR_RDATA.
  - Go to DONE.
- mem_ack and the timeout in the same cycle: the ack wins and mem_err is not set.
- DONE: unconditionally go to IDLE.
- Stall_M is combinational: Stall_M = (IDLE & access) | BUSY. It is 0 in DONE, so the pipeline advances at the end of DONE.
- A new instruction in MEM is first evaluated in the IDLE cycle after DONE. The same instruction is never re-issued.
- Minimum cost is 3 cycles per access: IDLE, BUSY with ack in its first cycle, then DONE. Stall_M is 1 for 2 of those cycles.
- An ack received in IDLE or DONE (late or spurious) is ignored and changes no state.
- Reset values (rst=0 at a clk edge):
  - state=IDLE, counter=0, mem_err=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, ReadData_M=0.
  - Stall_M and Flush_W follow from IDLE with access as currently driven.
- A reset during BUSY drops mem_req at that edge. No completion is reported.
- Counter width is $clog2(TIMEOUT+1), with a minimum of 1 bit.

Decomposition:
- Shared package riscv_pipe_pkg holds:
  - the state enum (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - RESULTSRC_MEM = 2'b01;
  - the default ERR_RDATA.
- One natural sub-module, dmem_timeout_cnt: a clearable up-counter with a terminal-count flag, parameterised by TIMEOUT.

Test Plan:
- Load from 0x100 with ack after 3 BUSY cycles and mem_rdata=0x12345678:
  - mem_req is high for 3 cycles with mem_addr=0x100 and mem_we=0.
  - Stall_M is high for 4 cycles.
  - ReadData_M=0x12345678 in DONE; mem_err stays 0.
- Store of 0xCAFEBABE to 0x204 with ack in the first BUSY cycle:
  - mem_we=1 and mem_wdata=0xCAFEBABE.
  - Stall_M is high for 2 cycles; the access completes in 3 cycles.
- Load from 0x103:
  - No mem_req is issued.
  - mem_err=1, ReadData_M=ERR_RDATA, state goes IDLE->DONE->IDLE, and Stall_M is high for 1 cycle.
- TIMEOUT=4 with no ack:
  - mem_req is high for 4 cycles, then drops.
  - mem_err=1 and ReadData_M=ERR_RDATA.
  - A late ack in the following IDLE cycle causes no state change.
- Two back-to-back loads, each acked in its first BUSY cycle: two separate transactions with no re-issue, 6 cycles in total.
- rst=0 asserted in the second BUSY cycle:
  - At the next edge, mem_req=0, state=IDLE, mem_err=0 and ReadData_M=0.
